// File: rtl/spm_loader_pkg.sv
// Shared definitions for the SPM boot loader: sequencer states and SPM test-port
// strobe levels.
package spm_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_VERIFY = 3'd2,
      ST_RUN    = 3'd3,
      ST_ERR    = 3'd4
   } state_t;

   localparam logic SPM_READ       = 1'b1;
   localparam logic SPM_WRITE      = 1'b0;
   localparam logic SPM_AS_ENABLE  = 1'b0;
   localparam logic SPM_AS_DISABLE = 1'b1;

endpackage

// File: rtl/spm_loader_csum.sv
// Running XOR-rotate checksum, csum = rotl(csum,1) ^ data, with clear and enable.
// sum_nx is the value the next enabled word produces, so a final word can be judged in its own cycle.
module spm_loader_csum #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] sum,
   output logic [DATA_W-1:0] sum_nx
);

   assign sum_nx = {sum[DATA_W-2:0], sum[DATA_W-1]} ^ data;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum_nx;
      end
   end

endmodule

// File: rtl/spm_boot_loader.sv
// Streams a program image into SPM over the test port, then releases cpu_en.
// Optional readback verify pass is built when SPM_BOOT_LOADER_VERIFY_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_LOAD   | accepting stream words, one SPM write per accepted word
// ST_VERIFY | re-reading the image and comparing checksums
// ST_RUN    | image in place, CPU released
// ST_ERR    | bad length or verify mismatch, CPU held
module spm_boot_loader
   import spm_loader_pkg::*;
#(
   parameter int  ADDR_W    = 30,
   parameter int  DATA_W    = 32,
   parameter int  MAX_WORDS = 1024,
   parameter int  RD_LAT    = 1,
   localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_cnt,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] test_spm_addr,
   output logic              test_spm_as_,
   output logic              test_spm_rw,
   output logic [DATA_W-1:0] test_spm_wr_data,
   input  logic [DATA_W-1:0] test_spm_rd_data,
   output logic              cpu_en,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  cnt_q, idx;
   logic              launch, accept, last_acc;

   // start is only honoured outside an active load/verify
   assign launch   = start && (state != ST_LOAD) && (state != ST_VERIFY);
   assign accept   = (state == ST_LOAD) && in_valid;
   assign last_acc = accept && (idx == cnt_q - CNT_W'(1));

`ifdef SPM_BOOT_LOADER_VERIFY_EN
   logic [CNT_W-1:0]  smp_cnt;
   logic [RD_LAT-1:0] rd_pipe;
   logic              issue, sample, final_smp, match;
   logic [DATA_W-1:0] csum_ld, csum_rd_nx, unused_ld_nx, unused_rd_sum;

   assign issue     = (state == ST_VERIFY) && (idx != cnt_q);
   assign sample    = rd_pipe[RD_LAT-1];
   assign final_smp = sample && (smp_cnt == cnt_q - CNT_W'(1));
   assign match     = (csum_rd_nx == csum_ld);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pipe <= '0;
         smp_cnt <= '0;
      end else begin
         rd_pipe <= RD_LAT'({rd_pipe, issue});
         if (launch) begin
            smp_cnt <= '0;
         end else if (sample) begin
            smp_cnt <= smp_cnt + CNT_W'(1);
         end
      end
   end

   spm_loader_csum #(.DATA_W(DATA_W)) u_csum_ld (
      .clk    (clk),
      .reset  (reset),
      .clear  (launch),
      .en     (accept),
      .data   (in_data),
      .sum    (csum_ld),
      .sum_nx (unused_ld_nx)
   );

   spm_loader_csum #(.DATA_W(DATA_W)) u_csum_rd (
      .clk    (clk),
      .reset  (reset),
      .clear  (launch),
      .en     (sample),
      .data   (test_spm_rd_data),
      .sum    (unused_rd_sum),
      .sum_nx (csum_rd_nx)
   );
`else
   logic unused_rd;
   assign unused_rd = ^test_spm_rd_data ^ (RD_LAT == 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         base_q <= '0;
         cnt_q  <= '0;
         idx    <= '0;
      end else begin
         state <= state_nx;
         if (launch) begin
            base_q <= base_addr;
            cnt_q  <= word_cnt;
            idx    <= '0;
         end else if (accept) begin
            idx <= last_acc ? '0 : idx + CNT_W'(1);
`ifdef SPM_BOOT_LOADER_VERIFY_EN
         end else if (issue) begin
            idx <= idx + CNT_W'(1);
`endif
         end
      end
   end

   always_comb begin
      state_nx = state;
      if (launch) begin
         if (word_cnt == '0) begin
            state_nx = ST_RUN;
         end else if (word_cnt > CNT_W'(MAX_WORDS)) begin
            state_nx = ST_ERR;
         end else begin
            state_nx = ST_LOAD;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (last_acc) begin
`ifdef SPM_BOOT_LOADER_VERIFY_EN
                  state_nx = ST_VERIFY;
`else
                  state_nx = ST_RUN;
`endif
               end
            end
`ifdef SPM_BOOT_LOADER_VERIFY_EN
            ST_VERIFY: begin
               if (final_smp) begin
                  state_nx = match ? ST_RUN : ST_ERR;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Strobe is combinational on state, so a reset edge drops it immediately
   always_comb begin
      in_ready         = (state == ST_LOAD);
      test_spm_as_     = SPM_AS_DISABLE;
      test_spm_rw      = SPM_READ;
      test_spm_addr    = '0;
      test_spm_wr_data = '0;
      if (accept) begin
         test_spm_as_     = SPM_AS_ENABLE;
         test_spm_rw      = SPM_WRITE;
         test_spm_addr    = base_q + ADDR_W'(idx);
         test_spm_wr_data = in_data;
      end
`ifdef SPM_BOOT_LOADER_VERIFY_EN
      if (issue) begin
         test_spm_as_  = SPM_AS_ENABLE;
         test_spm_addr = base_q + ADDR_W'(idx);
      end
`endif
      busy   = (state == ST_LOAD) || (state == ST_VERIFY);
      cpu_en = (state == ST_RUN) && !start;
      done   = (state == ST_RUN) && !start;
      error  = (state == ST_ERR) && !start;
   end

endmodule

// File: tb/tb_spm_boot_loader.sv
// Self-checking bench for spm_boot_loader: SPM model, stream driver and
// per-scenario checks against expected write/read sequences and release timing.
module tb_spm_boot_loader;

   localparam int ADDR_W    = 30;
   localparam int DATA_W    = 32;
   localparam int MAX_WORDS = 16;
   localparam int RD_LAT    = 1;
   localparam int CNT_W     = $clog2(MAX_WORDS + 1);
`ifdef SPM_BOOT_LOADER_VERIFY_EN
   localparam int VFY = 1;
`else
   localparam int VFY = 0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  word_cnt = '0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic [ADDR_W-1:0] test_spm_addr;
   logic              test_spm_as_;
   logic              test_spm_rw;
   logic [DATA_W-1:0] test_spm_wr_data;
   logic [DATA_W-1:0] test_spm_rd_data = '0;
   logic              cpu_en, busy, done, error;

   spm_boot_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .RD_LAT(RD_LAT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .base_addr        (base_addr),
      .word_cnt         (word_cnt),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_ready         (in_ready),
      .test_spm_addr    (test_spm_addr),
      .test_spm_as_     (test_spm_as_),
      .test_spm_rw      (test_spm_rw),
      .test_spm_wr_data (test_spm_wr_data),
      .test_spm_rd_data (test_spm_rd_data),
      .cpu_en           (cpu_en),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      int                c;
   } acc_t;

   int total = 0;
   int bad = 0;
   int gcyc = 0;
   int t0 = 0;
   acc_t wq[$];
   acc_t rq[$];
   int drv_cyc[$];
   logic [DATA_W-1:0] img [0:MAX_WORDS];
   logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
   logic              corrupt = 1'b0;
   logic [ADDR_W-1:0] corrupt_addr = '0;
   logic [DATA_W-1:0] rd_pend = '0;
   logic [DATA_W-1:0] rd_line [RD_LAT];
   logic              en_at_start, err_at_start;

   localparam logic [68:0] RST_VEC = {1'b0, 1'b1, 1'b1, 30'd0, 32'd0, 4'b0000};

   // SPM model: observe strobes mid-cycle, return read data RD_LAT cycles later
   always @(negedge clk) begin
      if (test_spm_as_ === 1'b0) begin
         if (test_spm_rw === 1'b0) begin
            wq.push_back('{a: test_spm_addr, d: test_spm_wr_data, c: gcyc - t0});
            mem[test_spm_addr] = test_spm_wr_data;
         end else begin
            rq.push_back('{a: test_spm_addr, d: '0, c: gcyc - t0});
            rd_pend = mem.exists(test_spm_addr) ? mem[test_spm_addr] : '0;
            if (corrupt && test_spm_addr == corrupt_addr) rd_pend = rd_pend ^ 32'h1;
         end
      end
   end

   always @(posedge clk) begin
      gcyc++;
      #1;
      for (int i = RD_LAT - 1; i > 0; i--) rd_line[i] = rd_line[i-1];
      rd_line[0] = rd_pend;
      test_spm_rd_data = rd_line[RD_LAT-1];
      rd_pend = '0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   // Stream driver: mode 0 always valid, 1 every other cycle, 2 random, 3 never.
   // Ready is expected to be high throughout LOAD, so every driven word counts as accepted.
   task automatic drive_load(input logic [ADDR_W-1:0] base, input int cnt, input int mode,
                             output int n_cyc);
      int sent;
      int cyc;
      sent = 0;
      cyc = 0;
      n_cyc = -1;
      wq.delete();
      rq.delete();
      drv_cyc.delete();
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = base;
      word_cnt = CNT_W'(cnt);
      @(negedge clk);
      en_at_start = cpu_en;
      err_at_start = error;
      @(posedge clk); #1;
      start = 1'b0;
      t0 = gcyc;
      while (cyc < 8 * MAX_WORDS + 64) begin
         case (mode)
            0: in_valid = 1'b1;
            1: in_valid = (cyc % 2 == 0);
            2: in_valid = ($urandom_range(3, 0) != 0);
            default: in_valid = 1'b0;
         endcase
         in_valid = in_valid && (sent < cnt);
         in_data = (sent < cnt) ? img[sent] : '0;
         if (in_valid) begin
            drv_cyc.push_back(cyc);
            sent++;
         end
         @(negedge clk);
         if (cpu_en === 1'b1 || error === 1'b1) begin
            n_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      in_data = '0;
   endtask

   task automatic test_reset();
      logic [68:0] got;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = {in_ready, test_spm_as_, test_spm_rw, test_spm_addr, test_spm_wr_data,
             cpu_en, busy, done, error};
      total++;
      if (got !== RST_VEC) begin
         bad++;
         $display("FAIL reset_held: got=%h exp=%h", got, RST_VEC);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      got = {in_ready, test_spm_as_, test_spm_rw, test_spm_addr, test_spm_wr_data,
             cpu_en, busy, done, error};
      total++;
      if (got !== RST_VEC) begin
         bad++;
         $display("FAIL idle_after_reset: got=%h exp=%h", got, RST_VEC);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int exp_n;
      img[0] = 32'h0000_0013;
      img[1] = 32'h0010_0093;
      img[2] = 32'h0020_0113;
      img[3] = 32'h0030_0193;
      drive_load('0, 4, 0, n);
      total++;
      if (wq.size() != 4) begin
         bad++;
         $display("FAIL b2b_write_count: got=%0d exp=4", wq.size());
      end
      for (int i = 0; i < wq.size() && i < 4; i++) begin
         total++;
         if (wq[i].a !== ADDR_W'(i) || wq[i].d !== img[i] || wq[i].c != i) begin
            bad++;
            $display("FAIL b2b_write%0d: got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                     i, wq[i].a, wq[i].d, wq[i].c, i, img[i], i);
         end
      end
      exp_n = 4 + VFY * (4 + RD_LAT);
      total++;
      if (n != exp_n) begin
         bad++;
         $display("FAIL b2b_release_cycle: got=%0d exp=%0d", n, exp_n);
      end
      total++;
      if ({cpu_en, done, busy, error} !== 4'b1100) begin
         bad++;
         $display("FAIL b2b_run_flags: got=%b exp=1100", {cpu_en, done, busy, error});
      end
      total++;
      if (rq.size() != VFY * 4) begin
         bad++;
         $display("FAIL b2b_read_count: got=%0d exp=%0d", rq.size(), VFY * 4);
      end
   endtask

   task automatic test_stall();
      int n;
      int exp_n;
      drive_load('0, 4, 1, n);
      total++;
      if (en_at_start !== 1'b0) begin
         bad++;
         $display("FAIL restart_drops_cpu_en: got=%b exp=0", en_at_start);
      end
      total++;
      if (wq.size() != 4) begin
         bad++;
         $display("FAIL stall_write_count: got=%0d exp=4", wq.size());
      end
      for (int i = 0; i < wq.size() && i < 4; i++) begin
         total++;
         if (wq[i].a !== ADDR_W'(i) || wq[i].d !== img[i] || wq[i].c != 2 * i) begin
            bad++;
            $display("FAIL stall_write%0d: got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                     i, wq[i].a, wq[i].d, wq[i].c, i, img[i], 2 * i);
         end
      end
      exp_n = 7 + VFY * (4 + RD_LAT);
      total++;
      if (n != exp_n) begin
         bad++;
         $display("FAIL stall_release_cycle: got=%0d exp=%0d", n, exp_n);
      end
   endtask

   task automatic test_wrap();
      int n;
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] ea;
      base = 30'h3FFF_FFFE;
      for (int i = 0; i < 4; i++) img[i] = $urandom();
      drive_load(base, 4, 0, n);
      total++;
      if (wq.size() != 4) begin
         bad++;
         $display("FAIL wrap_write_count: got=%0d exp=4", wq.size());
      end
      for (int i = 0; i < wq.size() && i < 4; i++) begin
         ea = base + ADDR_W'(i);
         total++;
         if (wq[i].a !== ea || wq[i].d !== img[i]) begin
            bad++;
            $display("FAIL wrap_write%0d: got addr=%h data=%h exp addr=%h data=%h",
                     i, wq[i].a, wq[i].d, ea, img[i]);
         end
      end
      total++;
      if ({cpu_en, error} !== 2'b10) begin
         bad++;
         $display("FAIL wrap_flags: got cpu_en,error=%b exp=10", {cpu_en, error});
      end
   endtask

   task automatic test_boundary();
      int n;
      int exp_n;
      drive_load(30'h100, 0, 0, n);
      total++;
      if (n != 0 || wq.size() != 0 || rq.size() != 0) begin
         bad++;
         $display("FAIL zero_len: got release=%0d writes=%0d reads=%0d exp 0/0/0",
                  n, wq.size(), rq.size());
      end
      drive_load(30'h100, MAX_WORDS + 1, 3, n);
      total++;
      if (n != 0 || {error, cpu_en, done} !== 3'b100 || wq.size() != 0) begin
         bad++;
         $display("FAIL over_len: got cyc=%0d err,en,done=%b writes=%0d exp 0/100/0",
                  n, {error, cpu_en, done}, wq.size());
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      total++;
      if ({error, cpu_en, busy} !== 3'b100) begin
         bad++;
         $display("FAIL err_sticky: got err,en,busy=%b exp=100", {error, cpu_en, busy});
      end
      for (int i = 0; i < MAX_WORDS; i++) img[i] = $urandom();
      drive_load(30'h200, MAX_WORDS, 0, n);
      total++;
      if (err_at_start !== 1'b0) begin
         bad++;
         $display("FAIL start_clears_error: got=%b exp=0", err_at_start);
      end
      exp_n = MAX_WORDS + VFY * (MAX_WORDS + RD_LAT);
      total++;
      if (n != exp_n || wq.size() != MAX_WORDS || error !== 1'b0) begin
         bad++;
         $display("FAIL max_len: got release=%0d writes=%0d err=%b exp %0d/%0d/0",
                  n, wq.size(), error, exp_n, MAX_WORDS);
      end
   endtask

   task automatic test_random();
      int n;
      int cnt;
      int exp_n;
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] ea;
      for (int k = 0; k < 6; k++) begin
         cnt = $urandom_range(MAX_WORDS, 1);
         base = ADDR_W'($urandom());
         for (int i = 0; i < cnt; i++) img[i] = $urandom();
         drive_load(base, cnt, 2, n);
         total++;
         if (wq.size() != cnt || drv_cyc.size() != cnt) begin
            bad++;
            $display("FAIL rand%0d_write_count: got=%0d exp=%0d", k, wq.size(), cnt);
         end
         for (int i = 0; i < wq.size() && i < cnt && i < drv_cyc.size(); i++) begin
            ea = base + ADDR_W'(i);
            total++;
            if (wq[i].a !== ea || wq[i].d !== img[i] || wq[i].c != drv_cyc[i]) begin
               bad++;
               $display("FAIL rand%0d_write%0d: got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                        k, i, wq[i].a, wq[i].d, wq[i].c, ea, img[i], drv_cyc[i]);
            end
         end
         exp_n = (drv_cyc.size() > 0 ? drv_cyc[drv_cyc.size()-1] : 0) + 1 + VFY * (cnt + RD_LAT);
         total++;
         if (n != exp_n || cpu_en !== 1'b1) begin
            bad++;
            $display("FAIL rand%0d_release: got cyc=%0d cpu_en=%b exp cyc=%0d cpu_en=1",
                     k, n, cpu_en, exp_n);
         end
      end
   endtask

`ifdef SPM_BOOT_LOADER_VERIFY_EN
   task automatic test_verify();
      int n;
      logic [ADDR_W-1:0] base;
      base = 30'h40;
      for (int i = 0; i < 4; i++) img[i] = $urandom();
      corrupt = 1'b1;
      corrupt_addr = base + ADDR_W'(2);
      drive_load(base, 4, 0, n);
      corrupt = 1'b0;
      total++;
      if (n != 4 + 4 + RD_LAT || {error, cpu_en, done} !== 3'b100) begin
         bad++;
         $display("FAIL verify_corrupt: got cyc=%0d err,en,done=%b exp cyc=%0d 100",
                  n, {error, cpu_en, done}, 4 + 4 + RD_LAT);
      end
      total++;
      if (rq.size() != 4) begin
         bad++;
         $display("FAIL verify_read_count: got=%0d exp=4", rq.size());
      end
      for (int i = 0; i < rq.size() && i < 4; i++) begin
         total++;
         if (rq[i].a !== base + ADDR_W'(i) || rq[i].c != 4 + i) begin
            bad++;
            $display("FAIL verify_read%0d: got addr=%h cyc=%0d exp addr=%h cyc=%0d",
                     i, rq[i].a, rq[i].c, base + ADDR_W'(i), 4 + i);
         end
      end
      drive_load(base, 4, 0, n);
      total++;
      if (n != 4 + 4 + RD_LAT || {error, cpu_en, done} !== 3'b011) begin
         bad++;
         $display("FAIL verify_clean: got cyc=%0d err,en,done=%b exp cyc=%0d 011",
                  n, {error, cpu_en, done}, 4 + 4 + RD_LAT);
      end
   endtask
`endif

   task automatic test_reset_mid();
      int n;
      logic [68:0] got;
      logic [ADDR_W-1:0] base;
      base = 30'd100;
      for (int i = 0; i < 4; i++) img[i] = $urandom();
      wq.delete();
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = base;
      word_cnt = CNT_W'(4);
      @(posedge clk); #1;
      start = 1'b0;
      t0 = gcyc;
      in_valid = 1'b1;
      in_data = img[0];
      @(posedge clk); #1;
      in_data = img[1];
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data = '0;
      @(negedge clk);
      total++;
      if ({busy, in_ready, test_spm_as_} !== 3'b111) begin
         bad++;
         $display("FAIL mid_load_stall: got busy,ready,as_=%b exp=111", {busy, in_ready, test_spm_as_});
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      got = {in_ready, test_spm_as_, test_spm_rw, test_spm_addr, test_spm_wr_data,
             cpu_en, busy, done, error};
      total++;
      if (got !== RST_VEC) begin
         bad++;
         $display("FAIL reset_mid_load: got=%h exp=%h", got, RST_VEC);
      end
      total++;
      if (wq.size() != 2) begin
         bad++;
         $display("FAIL partial_writes: got=%0d exp=2", wq.size());
      end
      @(posedge clk); #1;
      reset = 1'b0;
      drive_load(base, 4, 0, n);
      total++;
      if (wq.size() != 4) begin
         bad++;
         $display("FAIL reload_write_count: got=%0d exp=4", wq.size());
      end
      for (int i = 0; i < wq.size() && i < 4; i++) begin
         total++;
         if (wq[i].a !== base + ADDR_W'(i) || wq[i].d !== img[i]) begin
            bad++;
            $display("FAIL reload_write%0d: got addr=%h data=%h exp addr=%h data=%h",
                     i, wq[i].a, wq[i].d, base + ADDR_W'(i), img[i]);
         end
      end
      total++;
      if (n != 4 + VFY * (4 + RD_LAT) || cpu_en !== 1'b1) begin
         bad++;
         $display("FAIL reload_release: got cyc=%0d cpu_en=%b exp cyc=%0d cpu_en=1",
                  n, cpu_en, 4 + VFY * (4 + RD_LAT));
      end
   endtask

   initial begin
      for (int i = 0; i < RD_LAT; i++) rd_line[i] = '0;
      test_reset();
      test_back_to_back();
      test_stall();
      test_wrap();
      test_boundary();
      test_random();
`ifdef SPM_BOOT_LOADER_VERIFY_EN
      test_verify();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spm_boot_loader.md
Name: spm_boot_loader

Overview:
- Hardware boot loader that drives the SPM test port (`test_spm_*`) to copy a program image into SPM, then releases `cpu_en`.
- Replaces hand-written bench writes with a synthesizable sequencer.
- Image arrives as a valid/ready word stream.
- Parametrised in address width, data width and maximum image length.
- Optional readback verify pass.
- Sits between the external program source and `cpu_top`.

Parameters:
ADDR_W, 30, SPM word-address width (matches `test_spm_addr`)
DATA_W, 32, SPM word width
MAX_WORDS, 1024, maximum image length in words; count register is clog2(MAX_WORDS+1) bits
RD_LAT, 1, cycles from read strobe to valid `test_spm_rd_data` (1..3)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load when in IDLE
base_addr  in  ADDR_W  first SPM word address
word_cnt  in  clog2(MAX_WORDS+1)  words to load; sampled on start
in_valid  in  1  stream word valid
in_data  in  DATA_W  stream word
in_ready  out  1  loader accepts `in_data` this cycle
test_spm_addr  out  ADDR_W  SPM word address
test_spm_as_  out  1  address strobe, active low
test_spm_rw  out  1  1 = read, 0 = write
test_spm_wr_data  out  DATA_W  write data
test_spm_rd_data  in  DATA_W  read data
cpu_en  out  1  CPU run enable
busy  out  1  load or verify in progress
done  out  1  level; image loaded and CPU released
error  out  1  level; sticky until next start or reset

Behaviour:
Reset values:
- All outputs 0, except `test_spm_as_` = 1 and `test_spm_rw` = 1.
- State IDLE.

States: IDLE, LOAD, VERIFY, RUN, ERR.

IDLE:
- On `start`, latch `base_addr` and `word_cnt`; clear `done`, `error` and `cpu_en`.
- word_cnt == 0 -> go straight to RUN the next cycle.
- word_cnt > MAX_WORDS -> go to ERR.
- Otherwise -> LOAD with idx = 0.
- `start` in any other state is ignored.

LOAD:
- `in_ready` = 1.
- On in_valid & in_ready, in the same cycle:
  - `test_spm_as_` = 0, `test_spm_rw` = 0;
  - addr = base + idx, truncated mod 2^ADDR_W (wrap-around allowed, no error);
  - `test_spm_wr_data` = `in_data`;
  - idx increments.
- Stream stall (in_valid = 0) -> `test_spm_as_` = 1 and no SPM access; there is no timeout.
- After the last word is written (idx == word_cnt-1 accepted): `in_ready` drops the next cycle, then -> VERIFY if enabled, else RUN.
- Write latency: one word per cycle, zero bubbles.

VERIFY (only with macro, see below).

RUN:
- `cpu_en` = 1, `done` = 1, `busy` = 0.
- Remains until reset.
- A new `start` re-enters IDLE behaviour: it deasserts `cpu_en` in the same cycle, then reloads.

ERR:
- `error` = 1, `cpu_en` = 0.
- Exits only via `start` or reset.

`busy` = 1 in LOAD and VERIFY.

Reset mid-operation:
- Returns to IDLE next edge.
- SPM strobe deasserted immediately at that edge.
- Partially written image is not cleared.

Optional Feature:
SPM_BOOT_LOADER_VERIFY_EN
- With the macro:
  - After LOAD, VERIFY re-reads every word: `test_spm_as_` = 0, `test_spm_rw` = 1, addr = base + idx, one issue per cycle.
  - Comparison reference is a per-word running XOR-rotate checksum accumulated during LOAD: csum = rotl(csum,1) ^ data.
  - Readback data is sampled RD_LAT cycles after each issue and folded into the same checksum function.
  - After the final sample: match -> RUN; mismatch -> ERR.
  - Verify duration = word_cnt + RD_LAT cycles.
- Without the macro: no checksum logic; LOAD goes directly to RUN; the read path (`test_spm_rd_data`) is unused.

Decomposition:
- Shared package `spm_loader_pkg`:
  - state encoding constants;
  - `SPM_READ` = 1, `SPM_WRITE` = 0;
  - `SPM_AS_ENABLE` = 0, `SPM_AS_DISABLE` = 1.
- One natural sub-module: `spm_loader_csum` (checksum accumulator with clear/enable, DATA_W-wide), instantiated twice under the macro (load-side and readback-side).

Test Plan:
1. start, base = 0, cnt = 4, stream 0x00000013 / 0x00100093 / 0x00200113 / 0x00300193 back-to-back -> four write strobes on consecutive cycles, addr 0..3; then `cpu_en` = 1, `done` = 1.
2. Same image with in_valid toggled every other cycle -> `test_spm_as_` = 1 on stall cycles, addr still 0..3 in order, `cpu_en` only after the 4th word.
3. base = 2^30-2, cnt = 4 -> addrs 0x3FFFFFFE, 0x3FFFFFFF, 0, 1; `error` = 0.
4. cnt = 0 -> `cpu_en` = 1 one cycle after start, no strobes. cnt = MAX_WORDS+1 -> `error` = 1, no strobes, `cpu_en` = 0.
5. With SPM_BOOT_LOADER_VERIFY_EN, SPM model corrupts word 2 (bit 0 flipped) on read -> ERR, `error` = 1, `cpu_en` = 0. With a clean model -> RUN after cnt + RD_LAT verify cycles.
6. reset asserted mid-LOAD after 2 words -> next edge: all outputs at reset values; a subsequent start reloads the full image from addr base.
